// File: rtl/pipe_pkg.sv
// pipe_pkg: stall indices, per-boundary payload widths, NOP encodings and field offsets
package pipe_pkg;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
    localparam int STALL_VEC_W = 6;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 113;
    localparam int EX_MEM_W = 38;
    localparam int MEM_WB_W = 38;

    localparam logic [7:0] EXE_NOP_OP   = 8'h00;
    localparam logic [2:0] EXE_RES_NOP  = 3'b000;
    localparam logic [4:0] NOPRegAddr   = 5'b00000;
    localparam logic       WriteDisable = 1'b0;

    localparam int ID_EX_LINK_OFS   = 0;
    localparam int ID_EX_WREG_OFS   = 32;
    localparam int ID_EX_WD_OFS     = 33;
    localparam int ID_EX_REG2_OFS   = 38;
    localparam int ID_EX_REG1_OFS   = 70;
    localparam int ID_EX_ALUSEL_OFS = 102;
    localparam int ID_EX_ALUOP_OFS  = 105;
    localparam int WB_WDATA_OFS     = 0;
    localparam int WB_WREG_OFS      = 32;
    localparam int WB_WD_OFS        = 33;

    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = '0;
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = {EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0,
                                                  NOPRegAddr, WriteDisable, 32'h0};
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {NOPRegAddr, WriteDisable, 32'h0};
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = {NOPRegAddr, WriteDisable, 32'h0};

    function automatic logic [ID_EX_W-1:0] pack_id_ex(
        input logic [7:0] aluop, input logic [2:0] alusel, input logic [31:0] reg1,
        input logic [31:0] reg2, input logic [4:0] wd, input logic wreg, input logic [31:0] link
    );
        return {aluop, alusel, reg1, reg2, wd, wreg, link};
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking precedence over increment
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with flush, bubble, hold and perf counters
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = ID_EX_W,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter int                STAGE   = STALL_ID,
    parameter int                STALL_W = STALL_VEC_W,
    parameter int                CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               clr_cnt,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_dslot,
    input  logic               next_dslot_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_dslot,
    output logic               dslot_o,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);
    generate
        if (STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
        end
    endgenerate

    logic              up, dn;
    logic              valid_q, valid_d, dslot_q, dslot_d, nds_q, nds_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign up = stall[STAGE];
    assign dn = stall[STAGE+1];

    // An illegal up=0/dn=1 falls through to the advance branch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        dslot_d = dslot_q;
        nds_d   = nds_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = NOP_VAL;
            dslot_d = 1'b0;
            nds_d   = 1'b0;
        end else if (up && !dn) begin
            valid_d = 1'b0;
            data_d  = NOP_VAL;
            dslot_d = 1'b0;
        end else if (!up) begin
            valid_d = in_valid;
            data_d  = in_valid ? in_data : NOP_VAL;
            dslot_d = in_valid & in_dslot;
            nds_d   = next_dslot_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VAL;
            dslot_q <= 1'b0;
            nds_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            dslot_q <= dslot_d;
            nds_q   <= nds_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk(clk), .rst(rst), .inc(!flush && up && !dn), .clr(clr_cnt), .count(bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk(clk), .rst(rst), .inc(!flush && up && dn), .clr(clr_cnt), .count(hold_cnt)
    );

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_dslot = dslot_q;
    assign dslot_o   = nds_q;

    assert property (@(posedge clk) disable iff (!rst) !(dn && !up));
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
    localparam int DW = 113;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] NOP  = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    stall = '0;
    logic          flush = 1'b0, clr_cnt = 1'b0, in_valid = 1'b0, in_dslot = 1'b0, next_dslot_i = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, out_dslot, dslot_o, v2, os2, ds2;
    logic [DW-1:0] out_data, d2;
    logic [15:0]   bubble_cnt, hold_cnt;
    logic [1:0]    bc2, hc2;
    int            n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .in_dslot(in_dslot), .next_dslot_i(next_dslot_i),
        .out_valid(out_valid), .out_data(out_data), .out_dslot(out_dslot), .dslot_o(dslot_o),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .in_dslot(in_dslot), .next_dslot_i(next_dslot_i),
        .out_valid(v2), .out_data(d2), .out_dslot(os2), .dslot_o(ds2),
        .bubble_cnt(bc2), .hold_cnt(hc2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = ONES; in_dslot = 1'b1; next_dslot_i = 1'b1; stall = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({out_valid, out_dslot, dslot_o} !== 3'b000 || out_data !== NOP || bubble_cnt !== 16'd0 || hold_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got v=%b ds=%b dso=%b data=%h bc=%0d hc=%0d, want all zero",
                         i, out_valid, out_dslot, dslot_o, out_data, bubble_cnt, hold_cnt);
            end
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== ONES) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b data=%h, want v=1 data=%h", out_valid, out_data, ONES);
        end
    endtask

    task automatic test_advance();
        stall = '0; in_valid = 1'b1; in_data = DW'(32'h1234_5678); in_dslot = 1'b1; next_dslot_i = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_data[31:0] !== 32'h1234_5678 || out_dslot !== 1'b1 || dslot_o !== 1'b1) begin
            n_fail++;
            $display("FAIL advance: got v=%b data=%h ds=%b dso=%b, want 1 12345678 1 1",
                     out_valid, out_data[31:0], out_dslot, dslot_o);
        end
    endtask

    task automatic test_bubble();
        stall = 6'b000111; next_dslot_i = 1'b0; in_data = DW'(32'hdead_beef);
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b0 || out_data !== NOP || out_dslot !== 1'b0 || dslot_o !== 1'b1) begin
                n_fail++;
                $display("FAIL bubble cyc%0d: got v=%b data=%h ds=%b dso=%b, want 0 NOP 0 1",
                         i, out_valid, out_data, out_dslot, dslot_o);
            end
        end
        n_tests++;
        if (bubble_cnt !== 16'd3 || hold_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL bubble_cnt: got bc=%0d hc=%0d, want bc=3 hc=0", bubble_cnt, hold_cnt);
        end
    endtask

    task automatic test_hold();
        stall = '0; in_valid = 1'b1; in_data = DW'(32'haaaa_0001); next_dslot_i = 1'b1;
        step();
        stall = 6'b001111;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(32'hbbbb_0000 + i);
            next_dslot_i = 1'b0;
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== DW'(32'haaaa_0001) || dslot_o !== 1'b1) begin
                n_fail++;
                $display("FAIL hold cyc%0d: got v=%b data=%h dso=%b, want 1 aaaa0001 1",
                         i, out_valid, out_data, dslot_o);
            end
        end
        n_tests++;
        if (hold_cnt !== 16'd4 || bubble_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL hold_cnt: got hc=%0d bc=%0d, want hc=4 bc=3", hold_cnt, bubble_cnt);
        end
        stall = '0; in_data = DW'(32'hcccc_0005); next_dslot_i = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== DW'(32'hcccc_0005)) begin
            n_fail++;
            $display("FAIL hold_release: got v=%b data=%h, want 1 cccc0005", out_valid, out_data);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; stall = 6'b001111; in_data = DW'(32'h5555_5555);
        step();
        flush = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== NOP || out_dslot !== 1'b0 || dslot_o !== 1'b0 || hold_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL flush: got v=%b data=%h ds=%b dso=%b hc=%0d, want 0 NOP 0 0 4",
                     out_valid, out_data, out_dslot, dslot_o, hold_cnt);
        end
    endtask

    task automatic test_invalid_capture();
        stall = '0; in_valid = 1'b0; in_data = DW'(32'h7777_7777); in_dslot = 1'b1; next_dslot_i = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== NOP || out_dslot !== 1'b0 || dslot_o !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_capture: got v=%b data=%h ds=%b dso=%b, want 0 NOP 0 1",
                     out_valid, out_data, out_dslot, dslot_o);
        end
    endtask

    task automatic test_saturation();
        clr_cnt = 1'b1; stall = '0;
        step();
        clr_cnt = 1'b0;
        n_tests++;
        if (bc2 !== 2'd0 || bubble_cnt !== 16'd0 || hold_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_idle: got bc2=%0d bc=%0d hc=%0d, want 0 0 0", bc2, bubble_cnt, hold_cnt);
        end
        stall = 6'b000111;
        for (int i = 0; i < 5; i++) step();
        n_tests++;
        if (bc2 !== 2'd3 || bubble_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL saturate: got bc2=%0d bc=%0d, want bc2=3 bc=5", bc2, bubble_cnt);
        end
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        n_tests++;
        if (bc2 !== 2'd0 || bubble_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_during_bubble: got bc2=%0d bc=%0d, want 0 0", bc2, bubble_cnt);
        end
    endtask

    task automatic test_reset_midstall();
        stall = 6'b001111; rst = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || dslot_o !== 1'b0 || bubble_cnt !== 16'd0 || hold_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_midstall: got v=%b dso=%b bc=%0d hc=%0d, want all zero",
                     out_valid, dslot_o, bubble_cnt, hold_cnt);
        end
        rst = 1'b1; stall = '0; in_valid = 1'b1; in_data = DW'(32'h0bad_cafe); in_dslot = 1'b0; next_dslot_i = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== DW'(32'h0bad_cafe) || hold_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_capture: got v=%b data=%h hc=%0d, want 1 0badcafe 0",
                     out_valid, out_data, hold_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_invalid_capture();
        test_saturation();
        test_reset_midstall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage core; the next generation of the fixed-field decode/execute register.
- Carries an opaque payload of DATA_W bits plus valid and delay-slot tags.
- Handles reset, flush, bubble insertion and hold from the global stall vector, with the stage position selected by parameter.
- Adds a synchronous flush and saturating bubble/hold counters for performance debug.
- One instance per stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 113, payload width (default = aluop 8 + alusel 3 + reg1 32 + reg2 32 + wd 5 + wreg 1 + link address 32)
NOP_VAL, {DATA_W{1'b0}}, payload value driven on reset, bubble, flush or invalid capture
STAGE, 2, index of the upstream stall bit; the downstream bit is STAGE+1
STALL_W, 6, width of the stall vector
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (0 = reset)
stall  in  STALL_W  global stall vector from the control block; 1 = stop
flush  in  1  kill the stage contents (exception/redirect)
clr_cnt  in  1  synchronously clear both counters
in_valid  in  1  upstream payload valid
in_data  in  DATA_W  upstream payload
in_dslot  in  1  upstream instruction is in a delay slot
next_dslot_i  in  1  the next instruction entering decode is a delay slot
out_valid  out  1  registered valid
out_data  out  DATA_W  registered payload
out_dslot  out  1  registered delay-slot tag
dslot_o  out  1  registered next-is-delay-slot flag, fed back to decode
bubble_cnt  out  CNT_W  count of bubble cycles
hold_cnt  out  CNT_W  count of hold cycles

Behaviour:
- All state updates occur on the rising edge of clk. Latency is 1 cycle from input to output.
- Define up = stall[STAGE] and dn = stall[STAGE+1].
- Per edge, the first matching row applies (priority order):
  1. rst==0: out_valid=0, out_data=NOP_VAL, out_dslot=0, dslot_o=0, bubble_cnt=0, hold_cnt=0. Every output has a defined reset value; no field is left unreset.
  2. flush==1: out_valid=0, out_data=NOP_VAL, out_dslot=0, dslot_o=0. Flush overrides any stall combination.
  3. up==1 && dn==0 (bubble): out_valid=0, out_data=NOP_VAL, out_dslot=0. dslot_o is held, so a pending delay slot is not lost while decode is stalled. bubble_cnt increments.
  4. up==1 && dn==1 (hold): all outputs keep their values. hold_cnt increments.
  5. up==0 (advance): dslot_o=next_dslot_i.
     - If in_valid==1: out_valid=1, out_data=in_data, out_dslot=in_dslot.
     - If in_valid==0: out_valid=0, out_data=NOP_VAL, out_dslot=0.
- up==0 && dn==1 is illegal: the control block guarantees stalls are monotonic. This combination is treated as advance, and an assertion fires in simulation.
- Counters:
  - Saturate at all-ones and never wrap.
  - clr_cnt zeroes both counters; a clear in the same cycle as an increment takes precedence.
  - Counters are unaffected by flush.
- Elaboration check: STAGE+1 < STALL_W. Otherwise raise a $error at elaboration.
- Reset in mid-stall: reset wins; the first cycle after reset obeys the table above with no residual state.
- Purely registered outputs: no combinational path from any input to any output.

Decomposition:
- Shared package (pipe_pkg):
  - stall index constants (STALL_PC=0, STALL_IF=1, STALL_ID=2, STALL_EX=3, STALL_MEM=4, STALL_WB=5)
  - per-boundary DATA_W constants and NOP_VAL encodings (EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr, WriteDisable packed)
  - payload field offset constants used by pack/unpack at each instance site
- One sub-module: sat_counter (CNT_W parameter; ports inc, clr, count), instantiated twice for bubble_cnt and hold_cnt.

Test Plan:
- Reset release: hold rst=0 for 2 cycles with in_data=all-ones and in_valid=1 -> out_valid=0, out_data=NOP_VAL, dslot_o=0 and both counters 0 at every edge; first edge with rst=1 and stall=0 captures all-ones.
- Advance: stall=6'b000000, in_valid=1, in_data=0x1234_5678 in low bits, in_dslot=1, next_dslot_i=1 -> next cycle out_valid=1, out_data low bits=0x1234_5678, out_dslot=1, dslot_o=1.
- Bubble: with the stage full, stall=6'b000111 for 3 cycles (STAGE=2) -> out_valid=0, out_data=NOP_VAL, out_dslot=0, dslot_o unchanged, bubble_cnt=3, hold_cnt=0.
- Hold: stall=6'b001111 for 4 cycles with in_data changing every cycle -> outputs frozen at the pre-stall value, hold_cnt=4; release to 0 -> the current in_data is captured one edge later.
- Flush priority: flush=1 together with stall=6'b001111 and dslot_o=1 -> next cycle out_valid=0, out_data=NOP_VAL, dslot_o=0, hold_cnt not incremented.
- Saturation/clear: CNT_W=2, 5 consecutive bubble cycles -> bubble_cnt=3 (stays 3); then clr_cnt=1 during a bubble cycle -> bubble_cnt=0.
